// File: rtl/uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : uart_tx
// Purpose  : 8N1 UART transmitter, LSB first, with a small byte FIFO in
//            front of the serializer. Frames are CLKS_PER_BIT sclk per bit.
// Ports    : sclk        - system clock, rising edge
//            rst_n       - asynchronous active-low reset
//            i8_data     - byte to transmit, qualified by i_valid
//            i_valid     - push request
//            o_ready     - FIFO can accept (from registered count)
//            o_uart_tx   - registered serial line, idle high
//            o_busy      - serializer is not in BUS_IDLE
//            o_drop      - one-cycle pulse: push refused because FIFO full
//            o8_tx_state - FSM state (debug)
//            o8_fifo_cnt - FIFO occupancy, zero-extended (debug)
// Revision : 1.0 - initial release
// ============================================================================
module uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       sclk,
  input  logic       rst_n,
  input  logic [7:0] i8_data,
  input  logic       i_valid,
  output logic       o_ready,
  output logic       o_uart_tx,
  output logic       o_busy,
  output logic       o_drop,
  output logic [7:0] o8_tx_state,
  output logic [7:0] o8_fifo_cnt
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(FIFO_DEPTH);
  localparam logic [15:0]      LAST_TICK = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    BUS_IDLE  = 2'd0,
    START_BIT = 2'd1,
    DATA_BITS = 2'd2,
    STOP_BIT  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [15:0]        clk_cnt_q, clk_cnt_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;
  logic [7:0]         shift_q, shift_d;
  logic               tx_q, tx_d;
  logic               drop_q, drop_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [7:0]         mem [FIFO_DEPTH];

  logic               push;
  logic               pop;
  logic               fifo_nonempty;
  logic               bit_done;

  // Ready comes from the registered count only, so a pop in the same cycle
  // never opens a slot for a push while full.
  assign o_ready       = (fifo_cnt_q < DEPTH_CNT);
  assign push          = i_valid && o_ready;
  assign fifo_nonempty = (fifo_cnt_q != '0);
  assign bit_done      = (clk_cnt_q == LAST_TICK);

  // --------------------------------------------------------------------------
  // Serializer FSM, next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q + 16'd1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    pop       = 1'b0;

    case (state_q)
      BUS_IDLE: begin
        clk_cnt_d = '0;
        if (fifo_nonempty) begin
          pop       = 1'b1;
          shift_d   = mem[rd_ptr_q];
          bit_cnt_d = '0;
          state_d   = START_BIT;
        end
      end
      START_BIT: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          state_d   = DATA_BITS;
        end
      end
      DATA_BITS: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          shift_d   = {1'b0, shift_q[7:1]};
          if (bit_cnt_q == 4'd7) begin
            bit_cnt_d = '0;
            state_d   = STOP_BIT;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
      end
      STOP_BIT: begin
        if (bit_done) begin
          clk_cnt_d = '0;
          // Chain straight into the next start bit so queued bytes go out
          // without an idle gap.
          if (fifo_nonempty) begin
            pop       = 1'b1;
            shift_d   = mem[rd_ptr_q];
            bit_cnt_d = '0;
            state_d   = START_BIT;
          end else begin
            state_d   = BUS_IDLE;
          end
        end
      end
      default: begin
        state_d   = BUS_IDLE;
        clk_cnt_d = '0;
      end
    endcase

    // The line is registered from the next state so it changes on the same
    // edge as the state (start bit low on the pop edge).
    case (state_d)
      START_BIT: tx_d = 1'b0;
      DATA_BITS: tx_d = shift_d[0];
      default:   tx_d = 1'b1;
    endcase
  end

  // --------------------------------------------------------------------------
  // FIFO bookkeeping
  // --------------------------------------------------------------------------
  always_comb begin
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    fifo_cnt_d = fifo_cnt_q;
    case ({push, pop})
      2'b10:   fifo_cnt_d = fifo_cnt_q + CNT_W'(1);
      2'b01:   fifo_cnt_d = fifo_cnt_q - CNT_W'(1);
      default: fifo_cnt_d = fifo_cnt_q;
    endcase
    drop_d = i_valid && !o_ready;
  end

  always_ff @(posedge sclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= BUS_IDLE;
      clk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      tx_q       <= 1'b1;
      drop_q     <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fifo_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      drop_q     <= drop_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  // Storage carries no reset; the count and pointers define what is valid.
  always_ff @(posedge sclk) begin
    if (push) begin
      mem[wr_ptr_q] <= i8_data;
    end
  end

  assign o_uart_tx   = tx_q;
  assign o_busy      = (state_q != BUS_IDLE);
  assign o_drop      = drop_q;
  assign o8_tx_state = {6'b0, state_q};
  assign o8_fifo_cnt = {{(8-CNT_W){1'b0}}, fifo_cnt_q};

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_tx
// Purpose  : Self-checking bench for uart_tx. Directed stimulus pushes the
//            expected bytes into a queue; a serial receiver model decodes
//            frames from the line and compares against the queue head.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_tx;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;

  logic       sclk    = 1'b0;
  logic       rst_n   = 1'b0;
  logic [7:0] i8_data = 8'h00;
  logic       i_valid = 1'b0;
  logic       o_ready;
  logic       o_uart_tx;
  logic       o_busy;
  logic       o_drop;
  logic [7:0] o8_tx_state;
  logic [7:0] o8_fifo_cnt;

  int         n_checks = 0;
  int         n_fail   = 0;
  logic [7:0] exp_q [$];

  uart_tx #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .sclk       (sclk),
    .rst_n      (rst_n),
    .i8_data    (i8_data),
    .i_valid    (i_valid),
    .o_ready    (o_ready),
    .o_uart_tx  (o_uart_tx),
    .o_busy     (o_busy),
    .o_drop     (o_drop),
    .o8_tx_state(o8_tx_state),
    .o8_fifo_cnt(o8_fifo_cnt)
  );

  always #5 sclk = ~sclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge sclk);
  endtask

  // --------------------------------------------------------------------------
  // Receiver model: samples mid-bit on the falling clock edge, abandons a
  // frame if reset is seen while it is in flight.
  // --------------------------------------------------------------------------
  task automatic mwait(input int n, inout bit ab);
    repeat (n) begin
      @(negedge sclk);
      if (!rst_n) ab = 1'b1;
    end
  endtask

  initial begin : monitor
    logic [7:0] rx;
    bit         ab;
    forever begin
      @(negedge sclk);
      if (rst_n && o_uart_tx == 1'b0) begin
        ab = 1'b0;
        rx = 8'h00;
        mwait(CPB/2, ab);
        if (!ab) check("rx_start_mid", o_uart_tx, 1'b0);
        for (int i = 0; i < 8; i++) begin
          if (!ab) begin
            mwait(CPB, ab);
            rx[i] = o_uart_tx;
          end
        end
        if (!ab) mwait(CPB, ab);
        if (!ab) begin
          check("rx_stop_bit", o_uart_tx, 1'b1);
          check("rx_frame_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) check("rx_byte", rx, exp_q.pop_front());
          mwait(CPB/2 - 1, ab);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int exp_cnt   [6] = '{1, 1, 2, 3, 4, 4};
  int exp_ready [6] = '{1, 1, 1, 1, 0, 0};
  int exp_drop  [6] = '{0, 0, 0, 0, 0, 1};

  initial begin : stim
    int  gaps;
    int  maxcnt;
    int  lows;
    bit  found;

    // ---------------- reset values ----------------
    tick(2);
    check("rst_tx",    o_uart_tx,   1);
    check("rst_busy",  o_busy,      0);
    check("rst_drop",  o_drop,      0);
    check("rst_state", o8_tx_state, 0);
    check("rst_cnt",   o8_fifo_cnt, 0);
    check("rst_ready", o_ready,     1);
    rst_n = 1'b1;
    tick(2);

    // ---------------- single byte 0xA5 ----------------
    i8_data = 8'hA5; i_valid = 1'b1; exp_q.push_back(8'hA5);
    tick(1);                                  // after edge k
    i_valid = 1'b0;
    check("sb_cnt_k",   o8_fifo_cnt, 1);
    check("sb_state_k", o8_tx_state, 0);
    check("sb_tx_k",    o_uart_tx,   1);
    tick(1);                                  // after k+1
    check("sb_tx_k1",    o_uart_tx,   0);
    check("sb_state_k1", o8_tx_state, 1);
    check("sb_busy_k1",  o_busy,      1);
    check("sb_cnt_k1",   o8_fifo_cnt, 0);
    tick(15);                                 // after k+16, last start cycle
    check("sb_tx_k16", o_uart_tx, 0);
    tick(1);                                  // after k+17, bit0 = 1
    check("sb_tx_k17", o_uart_tx, 1);
    tick(143);                                // after k+160, last stop cycle
    check("sb_busy_k160",  o_busy,      1);
    check("sb_state_k160", o8_tx_state, 3);
    tick(1);                                  // after k+161
    check("sb_busy_k161",  o_busy,      0);
    check("sb_state_k161", o8_tx_state, 0);

    // ---------------- back-to-back 0x00, 0xFF ----------------
    tick(3);
    i8_data = 8'h00; i_valid = 1'b1; exp_q.push_back(8'h00);
    tick(1);                                  // after k
    check("b2b_cnt_k", o8_fifo_cnt, 1);
    i8_data = 8'hFF; exp_q.push_back(8'hFF);
    tick(1);                                  // after k+1
    i_valid = 1'b0;
    check("b2b_cnt_k1", o8_fifo_cnt, 1);
    gaps = 0;
    for (int i = 2; i <= 320; i++) begin
      tick(1);
      if (!o_busy) gaps++;
      if (i == 160) check("b2b_cnt_k160", o8_fifo_cnt, 1);
      if (i == 161) begin
        check("b2b_cnt_k161",   o8_fifo_cnt, 0);
        check("b2b_state_k161", o8_tx_state, 1);
        check("b2b_tx_k161",    o_uart_tx,   0);
      end
    end
    check("b2b_idle_gaps", gaps, 0);
    tick(1);                                  // after k+321
    check("b2b_busy_end", o_busy, 0);

    // ---------------- overflow, depth 4 ----------------
    tick(3);
    i_valid = 1'b1;
    for (int d = 1; d <= 6; d++) begin
      i8_data = 8'(d);
      if (d <= 5) exp_q.push_back(8'(d));
      tick(1);
      check("ovf_cnt",   o8_fifo_cnt, exp_cnt[d-1]);
      check("ovf_ready", o_ready,     exp_ready[d-1]);
      check("ovf_drop",  o_drop,      exp_drop[d-1]);
    end
    i_valid = 1'b0;
    tick(1);
    check("ovf_drop_single", o_drop, 0);

    // ---------------- push while full across a pop ----------------
    i8_data = 8'h07; i_valid = 1'b1;
    found = 1'b0; maxcnt = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      tick(1);
      if (int'(o8_fifo_cnt) > maxcnt) maxcnt = int'(o8_fifo_cnt);
      if (o8_fifo_cnt == 8'd3) begin
        found = 1'b1;
        check("pwf_refused_drop", o_drop,  1);
        check("pwf_ready_after",  o_ready, 1);
        exp_q.push_back(8'h07);
        tick(1);
        i_valid = 1'b0;
        check("pwf_cnt_accept", o8_fifo_cnt, 4);
        check("pwf_drop_accept", o_drop,     0);
        check("pwf_ready_full",  o_ready,    0);
      end
    end
    check("pwf_pop_seen", found, 1);
    check("pwf_cnt_max_ok", maxcnt <= DEPTH, 1);
    found = 1'b0;
    for (int i = 0; i < 2000 && !found; i++) begin
      tick(1);
      if (!o_busy) found = 1'b1;
    end
    check("pwf_drain", found, 1);
    tick(2);
    check("pwf_all_frames", exp_q.size(), 0);
    check("pwf_line_idle",  o_uart_tx,    1);

    // ---------------- reset mid-frame ----------------
    tick(3);
    i8_data = 8'hC3; i_valid = 1'b1;          // no expectation: discarded
    tick(1);
    i8_data = 8'h5A;
    tick(1);                                  // after k+1, frame started
    i_valid = 1'b0;
    check("rmf_cnt_before", o8_fifo_cnt, 1);
    tick(68);                                 // after k+69: data bit 3
    check("rmf_state_data", o8_tx_state, 2);
    check("rmf_bit3_low",   o_uart_tx,   0);
    #2 rst_n = 1'b0;
    #1;
    check("rmf_tx_async", o_uart_tx,   1);
    check("rmf_cnt_zero", o8_fifo_cnt, 0);
    check("rmf_busy",     o_busy,      0);
    tick(3);
    rst_n = 1'b1;
    lows = 0;
    for (int i = 0; i < 250; i++) begin
      tick(1);
      if (!o_uart_tx || o_busy) lows++;
    end
    check("rmf_no_residual", lows, 0);
    check("rmf_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
